// File: rtl/cdn_usb4_os_pkg.sv
// USB4 ordered-set receive monitor: shared types and header constants.
package cdn_usb4_os_pkg;

  // Ordered-set classification reported on symbol_type.
  typedef enum logic [2:0] {
    OS_NONE  = 3'd0,
    OS_TS1   = 3'd1,
    OS_TS2   = 3'd2,
    OS_SLOS1 = 3'd3,
    OS_SLOS2 = 3'd4
  } os_type_e;

  // Framing states of the receive monitor.
  typedef enum logic [2:0] {
    ST_SEARCH         = 3'd0,
    ST_CAND_PAYLOAD   = 3'd1,
    ST_CAND_HEADER    = 3'd2,
    ST_LOCKED         = 3'd3,
    ST_LOCKED_PAYLOAD = 3'd4
  } rx_state_e;

  // 32-bit header identifiers for each ordered-set type.
  localparam logic [31:0] TS1_ID   = 32'h0F0F_A5A5;
  localparam logic [31:0] TS2_ID   = 32'h0F0F_5A5A;
  localparam logic [31:0] SLOS1_ID = 32'hF0F0_C3C3;
  localparam logic [31:0] SLOS2_ID = 32'hF0F0_3C3C;

  // True for the states in which the next valid word is a payload word.
  function automatic logic is_payload_state(input rx_state_e st);
    return (st == ST_CAND_PAYLOAD) || (st == ST_LOCKED_PAYLOAD);
  endfunction

endpackage

// File: rtl/cdn_usb4_os_id_match.sv
// Combinational header classifier: exact compare of one receive word
// against the four ordered-set identifiers.
module cdn_usb4_os_id_match
  import cdn_usb4_os_pkg::*;
(
  input  logic [31:0] word,
  output os_type_e    os_type,
  output logic        match
);

  // Exact 32-bit compare; anything unrecognised is OS_NONE with no match.
  always_comb begin
    os_type = OS_NONE;
    match   = 1'b0;
    if (word == TS1_ID) begin
      os_type = OS_TS1;
      match   = 1'b1;
    end else if (word == TS2_ID) begin
      os_type = OS_TS2;
      match   = 1'b1;
    end else if (word == SLOS1_ID) begin
      os_type = OS_SLOS1;
      match   = 1'b1;
    end else if (word == SLOS2_ID) begin
      os_type = OS_SLOS2;
      match   = 1'b1;
    end
  end

endmodule

// File: rtl/cdn_usb4_os_rx_monitor.sv
// USB4 ordered-set receive monitor. Acquires two-word ordered-set framing
// (header, payload) from an aligned parallel stream, holds lock until
// UNLOCK_COUNT consecutive bad headers, and keeps saturating per-type,
// total and error counters for ordered sets completed while locked.
module cdn_usb4_os_rx_monitor
  import cdn_usb4_os_pkg::*;
#(
  parameter int SERDES_WIDTH = 32,
  parameter int LOCK_COUNT   = 2,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pd_valid,
  input  logic [SERDES_WIDTH-1:0] pd_data,
  output logic                    symbol_lock,
  output logic [2:0]              symbol_type,
  output logic                    os_done,
  output logic [31:0]             ts1_received_count,
  output logic [31:0]             ts2_received_count,
  output logic [31:0]             slos1_received_count,
  output logic [31:0]             slos2_received_count,
  output logic [31:0]             os_count,
  output logic                    os_index,
  output logic [31:0]             err_count
);

  // Saturating +1: counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Next-state helper so os_index always tracks the word position the
  // FSM will expect after this edge.
  function automatic logic idx_of(input rx_state_e st);
    return is_payload_state(st);
  endfunction

  rx_state_e   state_p1;
  logic [31:0] good_cnt_p1;
  logic [31:0] bad_cnt_p1;
  os_type_e    hdr_type_p1;
  logic        lock_p1;
  os_type_e    type_p1;
  logic        vld_p1;
  logic        idx_p1;
  logic [31:0] ts1_cnt_p1;
  logic [31:0] ts2_cnt_p1;
  logic [31:0] slos1_cnt_p1;
  logic [31:0] slos2_cnt_p1;
  logic [31:0] os_cnt_p1;
  logic [31:0] err_cnt_p1;

  os_type_e    id_type_p0;
  logic        id_match_p0;

  // Stage 0: classify the incoming word as a candidate header.
  cdn_usb4_os_id_match u_id_match (
    .word    (pd_data[31:0]),
    .os_type (id_type_p0),
    .match   (id_match_p0)
  );

  // Stage 1: framing FSM and counters, all updated on the deciding word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1     <= ST_SEARCH;
      good_cnt_p1  <= '0;
      bad_cnt_p1   <= '0;
      hdr_type_p1  <= OS_NONE;
      lock_p1      <= 1'b0;
      type_p1      <= OS_NONE;
      vld_p1       <= 1'b0;
      idx_p1       <= 1'b0;
      ts1_cnt_p1   <= '0;
      ts2_cnt_p1   <= '0;
      slos1_cnt_p1 <= '0;
      slos2_cnt_p1 <= '0;
      os_cnt_p1    <= '0;
      err_cnt_p1   <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (pd_valid) begin
        case (state_p1)
          ST_SEARCH: begin
            if (id_match_p0) begin
              good_cnt_p1 <= 32'd1;
              if (32'(LOCK_COUNT) <= 32'd1) begin
                state_p1 <= ST_LOCKED_PAYLOAD;
                idx_p1   <= idx_of(ST_LOCKED_PAYLOAD);
              end else begin
                state_p1 <= ST_CAND_PAYLOAD;
                idx_p1   <= idx_of(ST_CAND_PAYLOAD);
              end
            end
          end

          ST_CAND_PAYLOAD: begin
            state_p1 <= ST_CAND_HEADER;
            idx_p1   <= idx_of(ST_CAND_HEADER);
          end

          ST_CAND_HEADER: begin
            if (id_match_p0) begin
              good_cnt_p1 <= good_cnt_p1 + 32'd1;
              if (good_cnt_p1 + 32'd1 >= 32'(LOCK_COUNT)) begin
                state_p1 <= ST_LOCKED_PAYLOAD;
                idx_p1   <= idx_of(ST_LOCKED_PAYLOAD);
              end else begin
                state_p1 <= ST_CAND_PAYLOAD;
                idx_p1   <= idx_of(ST_CAND_PAYLOAD);
              end
            end else begin
              // Re-evaluating this word in SEARCH: it is not a header,
              // so the search simply restarts from the next word.
              good_cnt_p1 <= '0;
              state_p1    <= ST_SEARCH;
              idx_p1      <= idx_of(ST_SEARCH);
            end
          end

          ST_LOCKED: begin
            if (id_match_p0) begin
              hdr_type_p1 <= id_type_p0;
              bad_cnt_p1  <= '0;
              state_p1    <= ST_LOCKED_PAYLOAD;
              idx_p1      <= idx_of(ST_LOCKED_PAYLOAD);
            end else begin
              err_cnt_p1 <= sat_inc(err_cnt_p1);
              if (bad_cnt_p1 + 32'd1 >= 32'(UNLOCK_COUNT)) begin
                lock_p1     <= 1'b0;
                bad_cnt_p1  <= '0;
                good_cnt_p1 <= '0;
                state_p1    <= ST_SEARCH;
                idx_p1      <= idx_of(ST_SEARCH);
              end else begin
                bad_cnt_p1  <= bad_cnt_p1 + 32'd1;
                hdr_type_p1 <= OS_NONE;
                state_p1    <= ST_LOCKED_PAYLOAD;
                idx_p1      <= idx_of(ST_LOCKED_PAYLOAD);
              end
            end
          end

          ST_LOCKED_PAYLOAD: begin
            state_p1 <= ST_LOCKED;
            idx_p1   <= idx_of(ST_LOCKED);
            if (!lock_p1) begin
              // Payload of the final candidate set: lock asserts here,
              // the set itself belongs to acquisition and is not counted.
              lock_p1 <= 1'b1;
            end else begin
              vld_p1    <= 1'b1;
              type_p1   <= hdr_type_p1;
              os_cnt_p1 <= sat_inc(os_cnt_p1);
              case (hdr_type_p1)
                OS_TS1:   ts1_cnt_p1   <= sat_inc(ts1_cnt_p1);
                OS_TS2:   ts2_cnt_p1   <= sat_inc(ts2_cnt_p1);
                OS_SLOS1: slos1_cnt_p1 <= sat_inc(slos1_cnt_p1);
                OS_SLOS2: slos2_cnt_p1 <= sat_inc(slos2_cnt_p1);
                default:  ;
              endcase
            end
          end

          default: begin
            state_p1 <= ST_SEARCH;
            idx_p1   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign symbol_lock          = lock_p1;
  assign symbol_type          = type_p1;
  assign os_done              = vld_p1;
  assign os_index             = idx_p1;
  assign ts1_received_count   = ts1_cnt_p1;
  assign ts2_received_count   = ts2_cnt_p1;
  assign slos1_received_count = slos1_cnt_p1;
  assign slos2_received_count = slos2_cnt_p1;
  assign os_count             = os_cnt_p1;
  assign err_count            = err_cnt_p1;

endmodule

// File: tb/tb_cdn_usb4_os_rx_monitor.sv
// Self-checking bench for cdn_usb4_os_rx_monitor: directed scenarios plus a
// randomized stream compared against a word-level behavioural model.
module tb_cdn_usb4_os_rx_monitor;
  import cdn_usb4_os_pkg::*;

  localparam int LOCK_N   = 2;
  localparam int UNLOCK_N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pd_valid;
  logic [31:0] pd_data;
  logic        symbol_lock;
  logic [2:0]  symbol_type;
  logic        os_done;
  logic [31:0] ts1_received_count, ts2_received_count;
  logic [31:0] slos1_received_count, slos2_received_count;
  logic [31:0] os_count, err_count;
  logic        os_index;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cdn_usb4_os_rx_monitor #(
    .SERDES_WIDTH (32),
    .LOCK_COUNT   (LOCK_N),
    .UNLOCK_COUNT (UNLOCK_N)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pd_valid             (pd_valid),
    .pd_data              (pd_data),
    .symbol_lock          (symbol_lock),
    .symbol_type          (symbol_type),
    .os_done              (os_done),
    .ts1_received_count   (ts1_received_count),
    .ts2_received_count   (ts2_received_count),
    .slos1_received_count (slos1_received_count),
    .slos2_received_count (slos2_received_count),
    .os_count             (os_count),
    .os_index             (os_index),
    .err_count            (err_count)
  );

  // Behavioural model: tracks framing as "locked", "expecting payload",
  // "lock pending" flags and run-length counts of good/bad headers.
  bit          m_locked, m_expect_pl, m_pending, m_done;
  int          m_good, m_bad;
  logic [2:0]  m_hdr, m_type;
  logic [31:0] m_ts1, m_ts2, m_s1, m_s2, m_os, m_err;

  function automatic logic [31:0] bump(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  function automatic logic [2:0] classify(input logic [31:0] w);
    if (w == 32'h0F0F_A5A5) return 3'd1;
    if (w == 32'h0F0F_5A5A) return 3'd2;
    if (w == 32'hF0F0_C3C3) return 3'd3;
    if (w == 32'hF0F0_3C3C) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [31:0] rand_payload();
    logic [31:0] w;
    w = $urandom;
    while (classify(w) != 3'd0) w = $urandom;
    return w;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_expect_pl = 0; m_pending = 0; m_done = 0;
    m_good = 0; m_bad = 0; m_hdr = 3'd0; m_type = 3'd0;
    m_ts1 = 0; m_ts2 = 0; m_s1 = 0; m_s2 = 0; m_os = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [31:0] w);
    logic [2:0] t;
    t = classify(w);
    if (m_expect_pl) begin
      m_expect_pl = 0;
      if (m_pending) begin
        m_pending = 0;
        m_locked  = 1;
      end else if (m_locked) begin
        m_done = 1;
        m_type = m_hdr;
        m_os   = bump(m_os);
        if (m_hdr == 3'd1) m_ts1 = bump(m_ts1);
        if (m_hdr == 3'd2) m_ts2 = bump(m_ts2);
        if (m_hdr == 3'd3) m_s1  = bump(m_s1);
        if (m_hdr == 3'd4) m_s2  = bump(m_s2);
      end
    end else if (m_locked) begin
      if (t != 3'd0) begin
        m_hdr = t; m_bad = 0; m_expect_pl = 1;
      end else begin
        m_err = bump(m_err);
        m_bad++;
        if (m_bad >= UNLOCK_N) begin
          m_locked = 0; m_bad = 0; m_good = 0;
        end else begin
          m_hdr = 3'd0; m_expect_pl = 1;
        end
      end
    end else begin
      if (t != 3'd0) begin
        m_good++;
        m_expect_pl = 1;
        if (m_good >= LOCK_N) m_pending = 1;
      end else begin
        m_good = 0;
      end
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after rising.
  task automatic cycle(input logic r, input logic v, input logic [31:0] d);
    @(negedge clk);
    rst = r; pd_valid = v; pd_data = d;
    @(posedge clk);
    #1;
    m_done = 0;
    if (r) model_reset();
    else if (v) model_step(d);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_lock(input logic [31:0] id);
    for (int i = 0; i < LOCK_N; i++) begin
      cycle(1'b0, 1'b1, id);
      cycle(1'b0, 1'b1, rand_payload());
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, TS1_ID);
    cycle(1'b1, 1'b1, TS1_ID);
    n_checks++;
    if ({symbol_lock, os_done, symbol_type, os_index} !== 6'b0)
      $display("FAIL reset_ctrl got lock=%0b done=%0b type=%0d idx=%0b want all 0",
               symbol_lock, os_done, symbol_type, os_index);
    else n_pass++;
    n_checks++;
    if ({ts1_received_count, ts2_received_count, slos1_received_count,
         slos2_received_count, os_count, err_count} !== 192'b0)
      $display("FAIL reset_counters got os=%0d err=%0d ts1=%0d want 0",
               os_count, err_count, ts1_received_count);
    else n_pass++;
  endtask

  task automatic test_lock_acquire();
    do_reset();
    cycle(1'b0, 1'b1, TS1_ID);
    cycle(1'b0, 1'b1, rand_payload());
    cycle(1'b0, 1'b1, TS1_ID);
    n_checks++;
    if (symbol_lock !== 1'b0 || os_index !== 1'b1)
      $display("FAIL lock_after3 got lock=%0b idx=%0b want lock=0 idx=1", symbol_lock, os_index);
    else n_pass++;
    cycle(1'b0, 1'b1, rand_payload());
    n_checks++;
    if (symbol_lock !== 1'b1 || os_count !== 32'd0 || os_done !== 1'b0)
      $display("FAIL lock_after4 got lock=%0b os=%0d done=%0b want 1/0/0", symbol_lock, os_count, os_done);
    else n_pass++;
    cycle(1'b0, 1'b1, TS1_ID);
    cycle(1'b0, 1'b1, rand_payload());
    n_checks++;
    if (ts1_received_count !== 32'd1 || os_count !== 32'd1 || os_done !== 1'b1 || symbol_type !== 3'd1)
      $display("FAIL lock_first_set got ts1=%0d os=%0d done=%0b type=%0d want 1/1/1/1",
               ts1_received_count, os_count, os_done, symbol_type);
    else n_pass++;
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (os_done !== 1'b0 || os_index !== 1'b0)
      $display("FAIL done_pulse got done=%0b idx=%0b want 0/0", os_done, os_index);
    else n_pass++;
  endtask

  task automatic test_unlock();
    do_reset();
    do_lock(TS1_ID);
    cycle(1'b0, 1'b1, TS1_ID);
    cycle(1'b0, 1'b1, rand_payload());
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 32'h0);
      n_checks++;
      if (symbol_lock !== (i < 3) || err_count !== 32'(i + 1))
        $display("FAIL unlock_hdr%0d got lock=%0b err=%0d want lock=%0b err=%0d",
                 i, symbol_lock, err_count, (i < 3), i + 1);
      else n_pass++;
      cycle(1'b0, 1'b1, rand_payload());
    end
    n_checks++;
    if (os_count !== 32'd4 || symbol_lock !== 1'b0 || ts1_received_count !== 32'd1)
      $display("FAIL unlock_counts got os=%0d lock=%0b ts1=%0d want 4/0/1",
               os_count, symbol_lock, ts1_received_count);
    else n_pass++;
  endtask

  task automatic test_bad_recover();
    do_reset();
    do_lock(TS1_ID);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 32'h0);
      cycle(1'b0, 1'b1, rand_payload());
    end
    cycle(1'b0, 1'b1, SLOS2_ID);
    cycle(1'b0, 1'b1, rand_payload());
    n_checks++;
    if (symbol_lock !== 1'b1 || slos2_received_count !== 32'd1 || err_count !== 32'd3 ||
        os_count !== 32'd4 || symbol_type !== 3'd4)
      $display("FAIL recover_slos2 got lock=%0b s2=%0d err=%0d os=%0d type=%0d want 1/1/3/4/4",
               symbol_lock, slos2_received_count, err_count, os_count, symbol_type);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 32'h0);
      cycle(1'b0, 1'b1, rand_payload());
    end
    n_checks++;
    if (symbol_lock !== 1'b1 || err_count !== 32'd6)
      $display("FAIL recover_badcnt_cleared got lock=%0b err=%0d want 1/6", symbol_lock, err_count);
    else n_pass++;
  endtask

  task automatic test_gaps();
    logic [31:0] seq [14];
    logic [31:0] ref_cnt [6];
    logic [31:0] got_cnt [6];
    seq = '{TS1_ID, 32'h1, TS1_ID, 32'h2, TS2_ID, 32'h3, 32'h0, 32'h4,
            SLOS1_ID, 32'h5, 32'h0, 32'h6, SLOS2_ID, 32'h7};
    do_reset();
    foreach (seq[i]) cycle(1'b0, 1'b1, seq[i]);
    ref_cnt = '{os_count, ts1_received_count, ts2_received_count,
                slos1_received_count, slos2_received_count, err_count};
    do_reset();
    foreach (seq[i]) begin
      cycle(1'b0, 1'b1, seq[i]);
      if (i % 2 == 0) begin
        for (int g = 0; g < 2; g++) begin
          cycle(1'b0, 1'b0, $urandom);
          n_checks++;
          if (os_index !== 1'b1)
            $display("FAIL gap_index word%0d got %0b want 1", i, os_index);
          else n_pass++;
        end
      end
    end
    got_cnt = '{os_count, ts1_received_count, ts2_received_count,
                slos1_received_count, slos2_received_count, err_count};
    n_checks++;
    if (got_cnt != ref_cnt)
      $display("FAIL gap_counts got os=%0d err=%0d want os=%0d err=%0d",
               got_cnt[0], got_cnt[5], ref_cnt[0], ref_cnt[5]);
    else n_pass++;
    n_checks++;
    if (os_count !== 32'd5 || err_count !== 32'd2 || ts2_received_count !== 32'd1 ||
        slos1_received_count !== 32'd1 || ts1_received_count !== 32'd0)
      $display("FAIL gap_abs got os=%0d err=%0d ts2=%0d s1=%0d ts1=%0d want 5/2/1/1/0",
               os_count, err_count, ts2_received_count, slos1_received_count, ts1_received_count);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    do_lock(TS2_ID);
    @(negedge clk);
    pd_valid = 1'b0;
    force dut.ts2_cnt_p1 = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.ts2_cnt_p1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, TS2_ID);
      cycle(1'b0, 1'b1, rand_payload());
      n_checks++;
      if (ts2_received_count !== 32'hFFFF_FFFF)
        $display("FAIL sat_ts2 set%0d got %h want ffffffff", i, ts2_received_count);
      else n_pass++;
    end
    n_checks++;
    if (os_count !== 32'd3)
      $display("FAIL sat_os got %0d want 3", os_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid_set();
    do_reset();
    do_lock(TS1_ID);
    cycle(1'b0, 1'b1, TS1_ID);
    cycle(1'b0, 1'b1, rand_payload());
    cycle(1'b0, 1'b1, TS1_ID);
    cycle(1'b1, 1'b1, rand_payload());
    n_checks++;
    if (os_count !== 32'd0 || ts1_received_count !== 32'd0 || symbol_lock !== 1'b0 || os_index !== 1'b0)
      $display("FAIL midrst got os=%0d ts1=%0d lock=%0b idx=%0b want 0/0/0/0",
               os_count, ts1_received_count, symbol_lock, os_index);
    else n_pass++;
    cycle(1'b0, 1'b1, rand_payload());
    n_checks++;
    if (os_index !== 1'b0 || symbol_lock !== 1'b0 || os_done !== 1'b0)
      $display("FAIL midrst_search got idx=%0b lock=%0b done=%0b want 0/0/0", os_index, symbol_lock, os_done);
    else n_pass++;
    cycle(1'b0, 1'b1, TS1_ID);
    n_checks++;
    if (os_index !== 1'b1 || symbol_lock !== 1'b0)
      $display("FAIL midrst_restart got idx=%0b lock=%0b want 1/0", os_index, symbol_lock);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] ids [4];
    logic [31:0] w;
    logic        r, v;
    int          pct;
    ids = '{TS1_ID, TS2_ID, SLOS1_ID, SLOS2_ID};
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      pct = ((c / 150) % 2 == 0) ? 85 : 35;
      r   = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < pct) w = ids[$urandom_range(0, 3)];
      else if ($urandom_range(0, 1) == 0) w = 32'h0;
      else w = rand_payload();
      cycle(r, v, w);
      n_checks++;
      if (symbol_lock !== m_locked || os_done !== m_done || os_index !== m_expect_pl ||
          symbol_type !== m_type)
        $display("FAIL rand_ctrl c%0d got lock=%0b done=%0b idx=%0b type=%0d want %0b/%0b/%0b/%0d",
                 c, symbol_lock, os_done, os_index, symbol_type, m_locked, m_done, m_expect_pl, m_type);
      else n_pass++;
      n_checks++;
      if (os_count !== m_os || err_count !== m_err || ts1_received_count !== m_ts1 ||
          ts2_received_count !== m_ts2 || slos1_received_count !== m_s1 ||
          slos2_received_count !== m_s2)
        $display("FAIL rand_cnt c%0d got os=%0d err=%0d ts=%0d/%0d sl=%0d/%0d want %0d/%0d %0d/%0d %0d/%0d",
                 c, os_count, err_count, ts1_received_count, ts2_received_count,
                 slos1_received_count, slos2_received_count, m_os, m_err, m_ts1, m_ts2, m_s1, m_s2);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; pd_valid = 1'b0; pd_data = '0;
    model_reset();
    test_reset();
    test_lock_acquire();
    test_unlock();
    test_bad_recover();
    test_gaps();
    test_saturation();
    test_reset_mid_set();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
